animation_sequencer: RTL and testbench

- Schedules which animation and which frame the LCD pixel path shows.
- Sits between the user "go" input, the per-animation sprite generators and the SPI LCD driver.
- Tracks frame timing and steps the frame index at a programmable rate.
- All animation switches and frame steps are committed only at the LCD driver's end-of-frame pulse, so a scan never tears.
- The pixel mux downstream selects source data using anim_idx/frame_idx.

---
 rtl/animation_sequencer.sv | 147 ++++++++++++++
 tb/tb_animation_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/animation_sequencer.sv
// Animation/frame scheduler for the LCD pixel path. Animation switches and
// frame steps are committed only on the LCD driver's end-of-frame pulse so a
// scan never shows two different sources.
module animation_sequencer #(
    parameter int unsigned NUM_ANIM = 4,
    parameter int unsigned ANIM_W   = 2,
    parameter int unsigned FRAMES_W = 3,
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned CNT_W    = 23
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         go,
    input  logic                         pause,
    input  logic                         frame_end,
    input  logic [NUM_ANIM*FRAMES_W-1:0] frame_count,
    output logic [ANIM_W-1:0]            anim_idx,
    output logic [FRAMES_W-1:0]          frame_idx,
    output logic                         switch_pending,
    output logic                         anim_changed,
    output logic                         frame_changed
);

    localparam int unsigned FC_W = FRAMES_W + 1;

    typedef enum logic {
        ST_PLAY    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ANIM_W-1:0]   anim_q, anim_d;
    logic [ANIM_W-1:0]   pend_q, pend_d;
    logic [FRAMES_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                adv_q, adv_d;
    logic                sw_pend_q;
    logic                anim_chg_q, anim_chg_d;
    logic                frame_chg_q, frame_chg_d;

    logic [FRAMES_W-1:0] count_slice;
    logic [FC_W-1:0]     eff_count;
    logic [FC_W-1:0]     frame_plus1;
    logic                tick;
    logic [ANIM_W-1:0]   anim_inc;
    logic [ANIM_W-1:0]   pend_inc;
    logic [ANIM_W-1:0]   pend_sel;

    // Next animation index with wrap at NUM_ANIM
    function automatic logic [ANIM_W-1:0] next_anim(input logic [ANIM_W-1:0] a);
        if (a >= ANIM_W'(NUM_ANIM - 1)) begin
            return '0;
        end
        return a + ANIM_W'(1);
    endfunction

    // Frame count of the committed animation; zero behaves as a single frame
    always_comb begin
        count_slice = '0;
        for (int unsigned k = 0; k < NUM_ANIM; k++) begin
            if (anim_q == ANIM_W'(k)) begin
                count_slice = frame_count[k*FRAMES_W +: FRAMES_W];
            end
        end
        eff_count   = (count_slice == '0) ? FC_W'(1) : FC_W'(count_slice);
        frame_plus1 = FC_W'(frame_q) + FC_W'(1);
        tick        = !pause && (cnt_q == CNT_W'(TICK_DIV - 1));
        anim_inc    = next_anim(anim_q);
        pend_inc    = next_anim(pend_q);
        pend_sel    = go ? pend_inc : pend_q;
    end

    // Next-state, tick counter and commit logic
    always_comb begin
        state_d     = state_q;
        anim_d      = anim_q;
        pend_d      = pend_q;
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        adv_d       = adv_q | tick;
        anim_chg_d  = 1'b0;
        frame_chg_d = 1'b0;

        if (!pause) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_PLAY: begin
                if (go) begin
                    pend_d  = anim_inc;
                    state_d = ST_PENDING;
                end
                if (frame_end && adv_q) begin
                    frame_d     = (frame_plus1 >= eff_count) ? '0 : FRAMES_W'(frame_plus1);
                    adv_d       = tick;
                    frame_chg_d = 1'b1;
                end
            end
            ST_PENDING: begin
                pend_d = pend_sel;
                if (frame_end) begin
                    anim_d      = pend_sel;
                    frame_d     = '0;
                    cnt_d       = '0;
                    adv_d       = 1'b0;
                    state_d     = ST_PLAY;
                    anim_chg_d  = 1'b1;
                    frame_chg_d = 1'b1;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_PLAY;
            anim_q      <= '0;
            pend_q      <= '0;
            frame_q     <= '0;
            cnt_q       <= '0;
            adv_q       <= 1'b0;
            sw_pend_q   <= 1'b0;
            anim_chg_q  <= 1'b0;
            frame_chg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            anim_q      <= anim_d;
            pend_q      <= pend_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            adv_q       <= adv_d;
            sw_pend_q   <= (state_d == ST_PENDING);
            anim_chg_q  <= anim_chg_d;
            frame_chg_q <= frame_chg_d;
        end
    end

    assign anim_idx       = anim_q;
    assign frame_idx      = frame_q;
    assign switch_pending = sw_pend_q;
    assign anim_changed   = anim_chg_q;
    assign frame_changed  = frame_chg_q;

endmodule

// File: tb/tb_animation_sequencer.sv
// Self-checking bench for animation_sequencer: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_animation_sequencer;

    localparam int unsigned NUM_ANIM = 4;
    localparam int unsigned ANIM_W   = 2;
    localparam int unsigned FRAMES_W = 3;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned CNT_W    = 23;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         go = 1'b0;
    logic                         pause = 1'b0;
    logic                         frame_end = 1'b0;
    logic [NUM_ANIM*FRAMES_W-1:0] frame_count = {3'd3, 3'd2, 3'd0, 3'd4};
    logic [ANIM_W-1:0]            anim_idx;
    logic [FRAMES_W-1:0]          frame_idx;
    logic                         switch_pending;
    logic                         anim_changed;
    logic                         frame_changed;

    int checks = 0;
    int errors = 0;

    // Behavioural reference state
    int  m_anim, m_frame, m_pa, m_cnt;
    bit  m_adv, m_pend, m_ach, m_fch;

    animation_sequencer #(
        .NUM_ANIM(NUM_ANIM), .ANIM_W(ANIM_W), .FRAMES_W(FRAMES_W),
        .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .pause(pause), .frame_end(frame_end),
        .frame_count(frame_count), .anim_idx(anim_idx), .frame_idx(frame_idx),
        .switch_pending(switch_pending), .anim_changed(anim_changed),
        .frame_changed(frame_changed)
    );

    always #5 clk = ~clk;

    function automatic int frames_of(input int a);
        int n;
        n = int'((frame_count >> (a * FRAMES_W)) & 12'h7);
        return (n == 0) ? 1 : n;
    endfunction

    // Reference model: what one clock edge does given the sampled inputs
    task automatic model_edge(input bit g, input bit fe, input bit p, input bit r);
        bit t;
        m_ach = 0;
        m_fch = 0;
        if (!r) begin
            m_anim = 0; m_frame = 0; m_pa = 0; m_cnt = 0;
            m_adv = 0; m_pend = 0;
            return;
        end
        t = !p && (m_cnt == TICK_DIV - 1);
        if (m_pend) begin
            if (g) m_pa = (m_pa + 1) % NUM_ANIM;
            if (fe) begin
                m_anim = m_pa; m_frame = 0; m_cnt = 0; m_adv = 0; m_pend = 0;
                m_ach = 1; m_fch = 1;
                return;
            end
        end else begin
            if (g) begin
                m_pa = (m_anim + 1) % NUM_ANIM;
                m_pend = 1;
            end
            if (fe && m_adv) begin
                m_frame = (m_frame + 1) % frames_of(m_anim);
                m_adv = 0;
                m_fch = 1;
            end
        end
        if (!p) m_cnt = t ? 0 : m_cnt + 1;
        if (t) m_adv = 1;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle
    task automatic cyc(input bit g, input bit fe, input bit p, input bit r);
        go = g; frame_end = fe; pause = p; rst_n = r;
        @(posedge clk);
        model_edge(g, fe, p, r);
        #1;
    endtask

    task automatic idle(input int n, input bit p);
        for (int i = 0; i < n; i++) cyc(0, 0, p, 1);
    endtask

    task automatic test_reset;
        cyc(0, 0, 0, 0);
        checks++;
        if (anim_idx !== 0 || frame_idx !== 0 || switch_pending !== 0 ||
            anim_changed !== 0 || frame_changed !== 0) begin
            errors++;
            $display("FAIL reset: got anim=%0d frame=%0d sp=%0b ac=%0b fc=%0b required all 0",
                     anim_idx, frame_idx, switch_pending, anim_changed, frame_changed);
        end
        idle(5, 0);
        cyc(0, 1, 0, 1);
        checks++;
        if (frame_idx !== 1 || frame_changed !== 1 || anim_idx !== 0) begin
            errors++;
            $display("FAIL first_step: got frame=%0d fc=%0b anim=%0d required 1 1 0",
                     frame_idx, frame_changed, anim_idx);
        end
        idle(1, 0);
        checks++;
        if (frame_changed !== 0) begin
            errors++;
            $display("FAIL fc_one_cycle: got %0b required 0", frame_changed);
        end
    endtask

    task automatic test_frame_sequence;
        int exp_seq[5] = '{1, 2, 3, 0, 1};
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            idle(4, 0);
            cyc(0, 1, 0, 1);
            checks++;
            if (frame_idx !== FRAMES_W'(exp_seq[i]) || frame_changed !== 1) begin
                errors++;
                $display("FAIL frame_seq[%0d]: got frame=%0d fc=%0b required %0d 1",
                         i, frame_idx, frame_changed, exp_seq[i]);
            end
        end
    endtask

    task automatic test_switch;
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (switch_pending !== 1 || anim_idx !== 0 || frame_idx !== 1) begin
                errors++;
                $display("FAIL pending[%0d]: got sp=%0b anim=%0d frame=%0d required 1 0 1",
                         i, switch_pending, anim_idx, frame_idx);
            end
            cyc(0, 0, 0, 1);
        end
        cyc(0, 1, 0, 1);
        checks++;
        if (anim_idx !== 1 || frame_idx !== 0 || anim_changed !== 1 ||
            frame_changed !== 1 || switch_pending !== 0) begin
            errors++;
            $display("FAIL commit: got anim=%0d frame=%0d ac=%0b fc=%0b sp=%0b required 1 0 1 1 0",
                     anim_idx, frame_idx, anim_changed, frame_changed, switch_pending);
        end
        idle(1, 0);
        checks++;
        if (anim_changed !== 0) begin
            errors++;
            $display("FAIL ac_one_cycle: got %0b required 0", anim_changed);
        end
    endtask

    task automatic test_back_to_back;
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        checks++;
        if (anim_idx !== 2) begin
            errors++;
            $display("FAIL to_anim2: got %0d required 2", anim_idx);
        end
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 1);
        checks++;
        if (anim_idx !== 1 || switch_pending !== 0 || anim_changed !== 1) begin
            errors++;
            $display("FAIL multi_go: got anim=%0d sp=%0b ac=%0b required 1 0 1",
                     anim_idx, switch_pending, anim_changed);
        end
    endtask

    task automatic test_zero_count;
        for (int i = 0; i < 3; i++) begin
            idle(4, 0);
            cyc(0, 1, 0, 1);
            checks++;
            if (frame_idx !== 0 || frame_changed !== 1) begin
                errors++;
                $display("FAIL zero_count[%0d]: got frame=%0d fc=%0b required 0 1",
                         i, frame_idx, frame_changed);
            end
        end
    endtask

    task automatic test_pause;
        for (int i = 0; i < 20; i++) begin
            cyc(0, (i % 4) == 3, 1, 1);
            checks++;
            if (frame_idx !== 0 || frame_changed !== 0) begin
                errors++;
                $display("FAIL pause[%0d]: got frame=%0d fc=%0b required 0 0",
                         i, frame_idx, frame_changed);
            end
        end
        cyc(1, 0, 1, 1);
        cyc(0, 1, 1, 1);
        checks++;
        if (anim_idx !== 2 || anim_changed !== 1) begin
            errors++;
            $display("FAIL pause_switch: got anim=%0d ac=%0b required 2 1", anim_idx, anim_changed);
        end
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 0);
        checks++;
        if (anim_idx !== 0 || switch_pending !== 0 || frame_idx !== 0) begin
            errors++;
            $display("FAIL reset_pending: got anim=%0d sp=%0b frame=%0d required 0 0 0",
                     anim_idx, switch_pending, frame_idx);
        end
    endtask

    task automatic test_random;
        bit p;
        p = 0;
        frame_count = NUM_ANIM*FRAMES_W'($urandom);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) p = ~p;
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, p,
                $urandom_range(0, 199) != 0);
            checks++;
            if (anim_idx !== ANIM_W'(m_anim) || frame_idx !== FRAMES_W'(m_frame) ||
                switch_pending !== m_pend || anim_changed !== m_ach ||
                frame_changed !== m_fch) begin
                errors++;
                $display("FAIL random[%0d]: got anim=%0d frame=%0d sp=%0b ac=%0b fc=%0b required %0d %0d %0b %0b %0b",
                         i, anim_idx, frame_idx, switch_pending, anim_changed, frame_changed,
                         m_anim, m_frame, m_pend, m_ach, m_fch);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_sequence();
        test_switch();
        test_back_to_back();
        test_zero_count();
        test_pause();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
